// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// default latencies and op-class decode helpers.
// Optional feature macro: MDU_MADD_EN (enables the MADD accumulate op).
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for several cycles and commit through the shadow.
    function automatic logic is_long_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: r = 1'b1;
`else
            OP_MADD: r = 1'b0;  // code reserved, behaves as undefined
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Any op the unit recognises; only these raise err when dropped.
    function automatic logic is_valid_op(input logic [2:0] op);
        return is_long_op(op) || (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: produces the {HI,LO} value an op would
// commit. Divide by zero returns the current {HI,LO} so a commit is a no-op.
// Optional feature macro: MDU_MADD_EN.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [2*WIDTH-1:0] a_sx_s, b_sx_s, a_zx_s, b_zx_s, smul_s, umul_s;
    logic               a_neg_s, b_neg_s, b_zero_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, b_mag_safe_s, b_u_safe_s;
    logic [WIDTH-1:0]   sq_mag_s, sr_mag_s, sdiv_q_s, sdiv_r_s, udiv_q_s, udiv_r_s;

    assign a_sx_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign a_zx_s = {{WIDTH{1'b0}}, src_a};
    assign b_zx_s = {{WIDTH{1'b0}}, src_b};
    assign smul_s = a_sx_s * b_sx_s;
    assign umul_s = a_zx_s * b_zx_s;

    // Signed divide on magnitudes so the most negative dividend is well defined.
    assign a_neg_s      = src_a[WIDTH-1];
    assign b_neg_s      = src_b[WIDTH-1];
    assign b_zero_s     = (src_b == ZERO);
    assign a_mag_s      = a_neg_s ? (ZERO - src_a) : src_a;
    assign b_mag_s      = b_neg_s ? (ZERO - src_b) : src_b;
    assign b_mag_safe_s = b_zero_s ? ONE : b_mag_s;
    assign b_u_safe_s   = b_zero_s ? ONE : src_b;
    assign sq_mag_s     = a_mag_s / b_mag_safe_s;
    assign sr_mag_s     = a_mag_s % b_mag_safe_s;
    assign sdiv_q_s     = (a_neg_s ^ b_neg_s) ? (ZERO - sq_mag_s) : sq_mag_s;
    assign sdiv_r_s     = a_neg_s ? (ZERO - sr_mag_s) : sr_mag_s;
    assign udiv_q_s     = src_a / b_u_safe_s;
    assign udiv_r_s     = src_a % b_u_safe_s;

    // Select the {HI,LO} image for the requested op.
    always_comb begin
        result = {hi, lo};
        case (op)
            OP_MULT:  result = smul_s;
            OP_MULTU: result = umul_s;
            OP_DIV:   result = b_zero_s ? {hi, lo} : {sdiv_r_s, sdiv_q_s};
            OP_DIVU:  result = b_zero_s ? {hi, lo} : {udiv_r_s, udiv_q_s};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + smul_s;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: models multi-cycle latency with a down counter,
// owns HI/LO, and requests D-stage stalls while an op is in flight.
// The result is computed at the start edge into a shadow and committed to
// HI/LO on the last busy edge. reset is async-assert; release is expected
// to be synchronous to clk.
// Optional feature macro: MDU_MADD_EN (MADD accumulate op).
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             md_in_d,
    output logic             busy,
    output logic             stall_md,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] shadow_q, shadow_d;
    logic [2*WIDTH-1:0] calc_result_s;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (calc_result_s)
    );

    // Next-state logic: accept ops when idle, count down and commit when busy.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && is_long_op(op)) begin
                    state_d  = ST_BUSY;
                    cnt_d    = is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                    shadow_d = calc_result_s;
                end else if (start && (op == OP_MTHI)) begin
                    hi_d = src_a;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d = src_a;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Any recognised op arriving now is dropped and flagged.
                err_d = start & is_valid_op(op);
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    hi_d    = shadow_q[2*WIDTH-1:WIDTH];
                    lo_d    = shadow_q[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    // State, counter, shadow and HI/LO registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            shadow_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            shadow_q <= shadow_d;
        end
    end

    assign busy     = busy_q;
    assign err      = err_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    // Stall also covers the start cycle so a dependent D-stage op never slips through.
    assign stall_md = md_in_d & (busy_q | (start & is_long_op(op)));

endmodule
